// File: rtl/tc_scan_ctrl_pkg.sv
// Shared types and constants for the tensor-core scan controller.
package tc_scan_ctrl_pkg;

   localparam int ID_W = 20;

   localparam logic signed [31:0] MIN_SCORE = 32'sh8000_0000;

   // Tensor-core result latency: input register plus 6 adder stages.
   localparam int TC_LATENCY = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/tc_id_fifo.sv
// In-order ID FIFO, first-word fall-through. A push is accepted while full
// only when a pop happens in the same cycle.
module tc_id_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tc_scan_ctrl.sv
// Scan controller: fetches cmd_count database vectors starting at
// cmd_base_id, streams them through the tensor core and keeps the best
// (highest signed) dot product.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_ISSUE | issuing fetch requests, bounded by MAX_OUTSTANDING
//   ST_DRAIN | all requests issued, collecting remaining results
//   ST_DONE  | done_valid high, outputs held until done_ready
module tc_scan_ctrl
   import tc_scan_ctrl_pkg::*;
#(
   parameter int ID_WIDTH        = ID_W,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ID_WIDTH-1:0] cmd_base_id,
   input  logic [ID_WIDTH-1:0] cmd_count,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ID_WIDTH-1:0] mem_req_id,
   input  logic                mem_rsp_valid,
   output logic                tc_valid_in,
   output logic [ID_WIDTH-1:0] tc_vec_id,
   input  logic                tc_valid_out,
   input  logic [ID_WIDTH-1:0] tc_id_out,
   input  logic signed [31:0]  tc_dot_product,
   output logic                done_valid,
   input  logic                done_ready,
   output logic [ID_WIDTH-1:0] best_id,
   output logic signed [31:0]  best_score,
   output logic [ID_WIDTH-1:0] result_count
);

   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

   scan_state_t         state;
   scan_state_t         state_nxt;
   logic [ID_WIDTH-1:0] base_q;
   logic [ID_WIDTH-1:0] count_q;
   logic [ID_WIDTH-1:0] issued_q;
   logic [ID_WIDTH-1:0] result_q;
   logic [ID_WIDTH-1:0] best_id_q;
   logic signed [31:0]  best_score_q;
   logic [OW-1:0]       outst_q;
   logic                err_q;
   logic                err_nxt;

   logic                fifo_full;
   logic                fifo_empty;
   logic [ID_WIDTH-1:0] fifo_head;

   logic                cmd_fire;
   logic                req_fire;
   logic                rsp_fire;
   logic                res_fire;
   logic                last_req;
   logic                last_res;

   // Handshakes; every output valid is forced low while rst is high.
   assign cmd_ready     = !rst && (state == ST_IDLE);
   assign mem_req_valid = !rst && (state == ST_ISSUE) &&
                          (outst_q < OW'(MAX_OUTSTANDING));
   assign done_valid    = !rst && (state == ST_DONE);
   assign mem_req_id    = base_q + issued_q;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign req_fire = mem_req_valid && mem_req_ready;
   // A response with nothing outstanding has no ID to attach; drop it.
   assign rsp_fire = !rst && mem_rsp_valid && !fifo_empty;
   assign res_fire = !rst && tc_valid_out &&
                     ((state == ST_ISSUE) || (state == ST_DRAIN));

   assign last_req = (issued_q + ID_WIDTH'(1)) == count_q;
   assign last_res = res_fire && ((result_q + ID_WIDTH'(1)) == count_q);

   assign tc_valid_in = rsp_fire;
   assign tc_vec_id   = fifo_head;

   assign best_id      = rst ? '0 : best_id_q;
   assign best_score   = rst ? MIN_SCORE : best_score_q;
   assign result_count = rst ? '0 : result_q;

   tc_id_fifo #(
      .W     (ID_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_fire),
      .din   (mem_req_id),
      .pop   (rsp_fire),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cmd_fire) state_nxt = (cmd_count == '0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (req_fire && last_req) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (last_res) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (done_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Sticky protocol error: stray response or a result while idle.
   always_comb begin
      err_nxt = err_q || (mem_rsp_valid && fifo_empty) ||
                (tc_valid_out && (state == ST_IDLE));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Scan datapath: command latch, issue/result counters, best tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q       <= '0;
         count_q      <= '0;
         issued_q     <= '0;
         result_q     <= '0;
         best_id_q    <= '0;
         best_score_q <= MIN_SCORE;
         outst_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q <= err_nxt;
         if (cmd_fire) begin
            base_q       <= cmd_base_id;
            count_q      <= cmd_count;
            issued_q     <= '0;
            result_q     <= '0;
            best_id_q    <= '0;
            best_score_q <= MIN_SCORE;
         end else begin
            if (req_fire) issued_q <= issued_q + ID_WIDTH'(1);
            if (res_fire) begin
               result_q <= result_q + ID_WIDTH'(1);
               // First result always loads; later ones only on a strict win.
               if ((result_q == '0) || (tc_dot_product > best_score_q)) begin
                  best_id_q    <= tc_id_out;
                  best_score_q <= tc_dot_product;
               end
            end
         end
         case ({req_fire, rsp_fire})
            2'b10:   outst_q <= outst_q + 1'b1;
            2'b01:   outst_q <= outst_q - 1'b1;
            default: outst_q <= outst_q;
         endcase
      end
   end

   // The error flag is sticky once raised.
   always @(posedge clk) begin
      if (!rst) assert (!err_q || err_nxt);
   end

endmodule

// File: tb/tb_tc_scan_ctrl.sv
// Directed bench for tc_scan_ctrl: table-driven scans plus hand sequences
// for request stall, outstanding limit and mid-scan reset.
module tb_tc_scan_ctrl;
   import tc_scan_ctrl_pkg::*;

   localparam int IDW  = 20;
   localparam int MAXO = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic [IDW-1:0]        cmd_base_id = '0;
   logic [IDW-1:0]        cmd_count = '0;
   logic                  mem_req_valid;
   logic                  mem_req_ready = 1'b1;
   logic [IDW-1:0]        mem_req_id;
   logic                  mem_rsp_valid = 1'b0;
   logic                  tc_valid_in;
   logic [IDW-1:0]        tc_vec_id;
   logic                  tc_valid_out = 1'b0;
   logic [IDW-1:0]        tc_id_out = '0;
   logic signed [31:0]    tc_dot_product = '0;
   logic                  done_valid;
   logic                  done_ready = 1'b0;
   logic [IDW-1:0]        best_id;
   logic signed [31:0]    best_score;
   logic [IDW-1:0]        result_count;

   always #5 clk = ~clk;

   tc_scan_ctrl #(
      .ID_WIDTH        (IDW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_base_id    (cmd_base_id),
      .cmd_count      (cmd_count),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_id     (mem_req_id),
      .mem_rsp_valid  (mem_rsp_valid),
      .tc_valid_in    (tc_valid_in),
      .tc_vec_id      (tc_vec_id),
      .tc_valid_out   (tc_valid_out),
      .tc_id_out      (tc_id_out),
      .tc_dot_product (tc_dot_product),
      .done_valid     (done_valid),
      .done_ready     (done_ready),
      .best_id        (best_id),
      .best_score     (best_score),
      .result_count   (result_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory and tensor-core model: responses two cycles after acceptance,
   // results TC_LATENCY cycles after issue, score looked up by ID offset.
   int                    cyc = 0;
   int                    rsp_due[$];
   logic [IDW-1:0]        req_log[$];
   logic [IDW-1:0]        tc_id_q[$];
   int                    tc_due_q[$];
   bit                    rsp_en = 1'b1;
   logic [IDW-1:0]        cur_base = '0;
   logic [7:0][31:0]      cur_sc = '0;
   int                    tc_out_cnt = 0;
   logic [IDW-1:0]        off;

   always @(posedge clk) begin
      if (mem_req_valid && mem_req_ready) begin
         req_log.push_back(mem_req_id);
         rsp_due.push_back(cyc + 2);
      end
      if (tc_valid_in) begin
         tc_id_q.push_back(tc_vec_id);
         tc_due_q.push_back(cyc + TC_LATENCY);
      end
      cyc++;
      #1;
      mem_rsp_valid = 1'b0;
      if (rsp_en && rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
         void'(rsp_due.pop_front());
         mem_rsp_valid = 1'b1;
      end
      tc_valid_out   = 1'b0;
      tc_id_out      = '0;
      tc_dot_product = '0;
      if (tc_due_q.size() > 0 && tc_due_q[0] <= cyc) begin
         off            = tc_id_q[0] - cur_base;
         tc_valid_out   = 1'b1;
         tc_dot_product = cur_sc[off[2:0]];
         tc_id_out      = tc_id_q.pop_front();
         void'(tc_due_q.pop_front());
         tc_out_cnt++;
      end
   end

   typedef struct {
      logic [IDW-1:0]   base;
      logic [IDW-1:0]   count;
      logic [7:0][31:0] sc;
      logic [IDW-1:0]   exp_id;
      logic [31:0]      exp_score;
      logic [IDW-1:0]   exp_cnt;
      int               hold;
   } vec_t;

   vec_t vt[6];

   function automatic logic [7:0][31:0] pack8(input int s[8]);
      logic [7:0][31:0] r;
      for (int i = 0; i < 8; i++) r[i] = s[i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_cmd(input logic [IDW-1:0] b, input logic [IDW-1:0] c);
      req_log.delete();
      cur_base    = b;
      cmd_base_id = b;
      cmd_count   = c;
      cmd_valid   = 1'b1;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int waited);
      waited = 0;
      while (!done_valid && waited < budget) begin
         step();
         waited++;
      end
      n_checks++;
      if (!done_valid) begin
         n_fail++;
         $display("FAIL done_timeout: done_valid 0 after %0d cycles, expected 1", budget);
      end
   endtask

   task automatic check_done(input logic [IDW-1:0] e_id, input logic [31:0] e_sc,
                             input logic [IDW-1:0] e_cnt, input int hold);
      done_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         chk("done_valid_hold", 32'(done_valid), 32'd1);
         chk("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
         chk("best_id", 32'(best_id), 32'(e_id));
         chk("best_score", best_score, e_sc);
         chk("result_count", 32'(result_count), 32'(e_cnt));
         step();
      end
      done_ready = 1'b1;
      chk("done_valid_at_ready", 32'(done_valid), 32'd1);
      step();
      done_ready = 1'b0;
      chk("back_to_idle", 32'(cmd_ready), 32'd1);
      chk("done_dropped", 32'(done_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int             w;
      int             t0;
      logic [IDW-1:0] e;

      vt[0] = '{base: 20'd100, count: 20'd4, sc: pack8('{5, -3, 9, 9, 0, 0, 0, 0}),
                exp_id: 20'd102, exp_score: 32'd9, exp_cnt: 20'd4, hold: 2};
      vt[1] = '{base: 20'hFFFFE, count: 20'd4, sc: pack8('{1, 2, 3, 4, 0, 0, 0, 0}),
                exp_id: 20'd1, exp_score: 32'd4, exp_cnt: 20'd4, hold: 1};
      vt[2] = '{base: 20'd123, count: 20'd0, sc: '0,
                exp_id: 20'd0, exp_score: 32'h8000_0000, exp_cnt: 20'd0, hold: 1};
      vt[3] = '{base: 20'd500, count: 20'd3, sc: pack8('{-7, -7, -7, 0, 0, 0, 0, 0}),
                exp_id: 20'd500, exp_score: 32'hFFFF_FFF9, exp_cnt: 20'd3, hold: 5};
      vt[4] = '{base: 20'd7, count: 20'd1, sc: pack8('{int'(32'h8000_0000), 0, 0, 0, 0, 0, 0, 0}),
                exp_id: 20'd7, exp_score: 32'h8000_0000, exp_cnt: 20'd1, hold: 1};
      vt[5] = '{base: 20'd40, count: 20'd5, sc: pack8('{-1, -5, 3, 2, 3, 0, 0, 0}),
                exp_id: 20'd42, exp_score: 32'd3, exp_cnt: 20'd5, hold: 1};

      // Reset values while rst is held.
      step();
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_tc_valid_in", 32'(tc_valid_in), 32'd0);
      chk("rst_done_valid", 32'(done_valid), 32'd0);
      chk("rst_best_id", 32'(best_id), 32'd0);
      chk("rst_best_score", best_score, 32'h8000_0000);
      chk("rst_result_count", 32'(result_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
      step();

      // Table-driven scans.
      for (int i = 0; i < 6; i++) begin
         cur_sc = vt[i].sc;
         start_cmd(vt[i].base, vt[i].count);
         wait_done(300, w);
         if (vt[i].count == '0) chk("zero_count_latency", 32'(w), 32'd0);
         chk("req_total", 32'(req_log.size()), 32'(vt[i].count));
         for (int j = 0; j < req_log.size(); j++) begin
            e = vt[i].base + IDW'(j);
            chk("req_id_order", 32'(req_log[j]), 32'(e));
         end
         check_done(vt[i].exp_id, vt[i].exp_score, vt[i].exp_cnt, vt[i].hold);
         step();
      end

      // Request must hold valid and ID while mem_req_ready is low.
      mem_req_ready = 1'b0;
      cur_sc = pack8('{4, 6, 0, 0, 0, 0, 0, 0});
      start_cmd(20'd300, 20'd2);
      for (int i = 0; i < 3; i++) begin
         chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
         chk("stall_req_id", 32'(mem_req_id), 32'd300);
         step();
      end
      mem_req_ready = 1'b1;
      wait_done(100, w);
      check_done(20'd301, 32'd6, 20'd2, 1);
      step();

      // Outstanding limit with responses withheld.
      rsp_en = 1'b0;
      cur_sc = '0;
      start_cmd(20'd1000, 20'd20);
      repeat (15) step();
      chk("outstanding_cap_reqs", 32'(req_log.size()), 32'(MAXO));
      chk("outstanding_cap_valid", 32'(mem_req_valid), 32'd0);
      rsp_en = 1'b1;
      w = 0;
      while (!mem_req_valid && w < 10) begin
         step();
         w++;
      end
      chk("issue_resumes", 32'(mem_req_valid), 32'd1);
      wait_done(500, w);
      chk("outstanding_total_reqs", 32'(req_log.size()), 32'd20);
      check_done(20'd1000, 32'd0, 20'd20, 1);
      step();

      // Reset in the middle of a scan.
      cur_sc = pack8('{1, 2, 3, 0, 0, 0, 0, 0});
      start_cmd(20'd50, 20'd3);
      w = 0;
      while (req_log.size() < 3 && w < 20) begin
         step();
         w++;
      end
      chk("midscan_reqs_issued", 32'(req_log.size()), 32'd3);
      step();
      rst = 1'b1;
      #1;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_tc_valid_in", 32'(tc_valid_in), 32'd0);
      chk("midrst_done_valid", 32'(done_valid), 32'd0);
      chk("midrst_best_id", 32'(best_id), 32'd0);
      chk("midrst_best_score", best_score, 32'h8000_0000);
      chk("midrst_result_count", 32'(result_count), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("cmd_ready_post_midrst", 32'(cmd_ready), 32'd1);
      t0 = tc_out_cnt;
      for (int i = 0; i < 15; i++) begin
         chk("late_result_no_done", 32'(done_valid), 32'd0);
         chk("late_result_ignored", 32'(result_count), 32'd0);
         step();
      end
      chk("late_results_seen", 32'(tc_out_cnt > t0), 32'd1);

      // A fresh scan runs normally after the reset.
      cur_sc = vt[0].sc;
      start_cmd(20'd100, 20'd4);
      wait_done(300, w);
      check_done(20'd102, 32'd9, 20'd4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
